// File: rtl/air_conditioner_zoned.sv
// air_conditioner_zoned
// Multi-zone cooling controller. Every zone runs its own IDLE/COOL/LOCKOUT
// state machine. A shared admission stage limits how many zones may cool at
// the same time.
//
// Ports
//   clk            : system clock, all state updates on the rising edge
//   reset          : asynchronous, active-low reset
//   enable         : global cooling permit
//   setpoint       : shared target temperature (unsigned, TEMP_W bits)
//   temp           : packed zone temperatures, zone i at [i*TEMP_W +: TEMP_W]
//   presence       : per-zone occupancy
//   window         : per-zone window-open sensor
//   heating_system : heater running; acts as a global interlock
//   ac_cool        : per-zone cooling command (zone is in COOL)
//   lockout        : per-zone post-stop lockout indicator (zone is in LOCKOUT)
//   active_count   : number of zones whose ac_cool is high
module air_conditioner_zoned #(
    parameter int ZONES      = 4,
    parameter int TEMP_W     = 8,
    parameter int HYST       = 2,
    parameter int MIN_ON     = 5,
    parameter int MIN_OFF    = 3,
    parameter int MAX_ACTIVE = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [TEMP_W-1:0]          setpoint,
    input  logic [ZONES*TEMP_W-1:0]    temp,
    input  logic [ZONES-1:0]           presence,
    input  logic [ZONES-1:0]           window,
    input  logic                       heating_system,
    output logic [ZONES-1:0]           ac_cool,
    output logic [ZONES-1:0]           lockout,
    output logic [$clog2(ZONES+1)-1:0] active_count
);

    localparam int AW      = $clog2(ZONES + 1);
    localparam int TW1     = TEMP_W + 1;
    localparam int CNT_MAX = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_COOL = 2'd1;
    localparam logic [1:0] ST_LOCK = 2'd2;

    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(MIN_OFF - 1);
    localparam logic [AW-1:0]    MAX_A    = AW'(MAX_ACTIVE);
    localparam logic [TW1-1:0]   HYST_EXT = TW1'(HYST);

    logic [1:0]        state_q [ZONES];
    logic [1:0]        state_d [ZONES];
    logic [CNT_W-1:0]  cnt_q   [ZONES];
    logic [CNT_W-1:0]  cnt_d   [ZONES];

    logic [TEMP_W-1:0] zone_temp_s [ZONES];
    logic [TW1-1:0]    thr_s;
    logic [ZONES-1:0]  req_s;
    logic [ZONES-1:0]  safety_s;
    logic [ZONES-1:0]  stop_s;
    logic [ZONES-1:0]  grant_s;
    logic [AW-1:0]     budget_s;
    logic [AW-1:0]     count_s;

    // One extra bit on the threshold so a setpoint near full scale cannot
    // wrap around and make every zone look hot.
    assign thr_s = {1'b0, setpoint} + HYST_EXT;

    // Per-zone request, safety-trip and normal-stop conditions.
    always_comb begin
        for (int i = 0; i < ZONES; i++) begin
            zone_temp_s[i] = temp[i*TEMP_W +: TEMP_W];
            safety_s[i]    = window[i] | heating_system | ~enable;
            req_s[i]       = ({1'b0, zone_temp_s[i]} > thr_s) & presence[i] & ~safety_s[i];
            stop_s[i]      = (zone_temp_s[i] <= setpoint) | ~presence[i];
        end
    end

    // Ascending-index admission. The budget starts from the registered count,
    // so a zone leaving COOL on this edge still occupies its slot.
    always_comb begin
        budget_s = active_count;
        grant_s  = '0;
        for (int i = 0; i < ZONES; i++) begin
            if ((state_q[i] == ST_IDLE) && req_s[i] && (budget_s < MAX_A)) begin
                grant_s[i] = 1'b1;
                budget_s   = budget_s + AW'(1);
            end else begin
                grant_s[i] = 1'b0;
            end
        end
    end

    // Per-zone next state; the counter restarts on every state change and
    // otherwise saturates.
    always_comb begin
        for (int i = 0; i < ZONES; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = (cnt_q[i] == CNT_SAT) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
            case (state_q[i])
                ST_IDLE: begin
                    if (grant_s[i]) begin
                        state_d[i] = ST_COOL;
                        cnt_d[i]   = '0;
                    end else begin
                        state_d[i] = ST_IDLE;
                    end
                end
                ST_COOL: begin
                    // Safety trip wins over the minimum on-time.
                    if (safety_s[i]) begin
                        state_d[i] = ST_LOCK;
                        cnt_d[i]   = '0;
                    end else if (stop_s[i] && (cnt_q[i] >= ON_LAST)) begin
                        state_d[i] = ST_LOCK;
                        cnt_d[i]   = '0;
                    end else begin
                        state_d[i] = ST_COOL;
                    end
                end
                ST_LOCK: begin
                    if (cnt_q[i] >= OFF_LAST) begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end else begin
                        state_d[i] = ST_LOCK;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ZONES; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < ZONES; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Output decode from registered state only.
    always_comb begin
        count_s = '0;
        for (int i = 0; i < ZONES; i++) begin
            ac_cool[i] = (state_q[i] == ST_COOL);
            lockout[i] = (state_q[i] == ST_LOCK);
            count_s    = count_s + AW'(ac_cool[i]);
        end
    end

    assign active_count = count_s;

endmodule
